// File: rtl/uart_tx_if.sv
// Byte handshake between a byte source and the UART transmitter.
// The source drives data/valid; the transmitter answers with ready.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB-first, one stop bit.
// A byte is accepted only in IDLE; the serial line always comes straight from a flop.
module uart_tx #(
  parameter int CLK_PER_BIT = 87
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_tx_if.slave  tx_if,
  output logic      serial_out,
  output logic      busy,
  output logic      tx_done
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             serial_q, serial_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end        = (cnt_q == CNT_MAX);
  assign tx_if.tx_ready = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign serial_out     = serial_q;
  assign tx_done        = done_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        cnt_d    = '0;
        idx_d    = 3'd0;
        if (tx_if.tx_valid) begin
          shift_d  = tx_if.tx_data;
          serial_d = 1'b0;
          state_d  = START;
        end
      end

      // The shift register moves right each time a data bit is launched,
      // so the next bit to send is always shift_q[0].
      START: begin
        if (bit_end) begin
          cnt_d    = '0;
          idx_d    = 3'd0;
          serial_d = shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
          state_d  = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            idx_d    = 3'd0;
            serial_d = 1'b1;
            state_d  = STOP;
          end else begin
            idx_d    = idx_q + 3'd1;
            serial_d = shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
        cnt_d    = '0;
        idx_d    = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a timed driver queues the expected bytes and start cycles,
// and a receiver-style monitor decodes each frame off the line and scores it.
module tb_uart_tx;

  localparam int CPB   = 87;
  localparam int FRAME = 10 * CPB;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  logic clk;
  logic rst_n;
  logic serial_out;
  logic busy;
  logic tx_done;

  uart_tx_if tx_if ();

  uart_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_if      (tx_if.slave),
    .serial_out (serial_out),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  exp_t exp_q[$];
  int   cyc         = 0;
  int   done_cnt    = 0;
  int   tests       = 0;
  int   fails       = 0;
  int   frames_done = 0;
  int   frames_abrt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Queue the byte with the cycle its start bit must appear, then present it
  // on the handshake one negedge before that edge. Data changes right away so
  // that a held-valid sequence also proves post-accept data is ignored.
  task automatic applyStimulus(input logic [7:0] data, input int start, input bit hold);
    exp_t e;
    e.data  = data;
    e.start = start;
    exp_q.push_back(e);
    tx_if.tx_data = data;
    waitUntil(start - 1);
    tx_if.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) tx_if.tx_valid = 1'b0;
  endtask

  task automatic runFrame();
    exp_t       e;
    logic [9:0] bits;
    int         start;
    int         glitch;
    int         flag_err;
    bit         have_exp;
    start    = cyc;
    glitch   = 0;
    flag_err = 0;
    bits     = '0;
    have_exp = (exp_q.size() != 0);
    if (have_exp) begin
      e = exp_q.pop_front();
      checkOutput("start_time", start, e.start);
    end else begin
      checkOutput("unexpected_frame", 32'd1, 32'd0);
    end
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < CPB; k++) begin
        if (b != 0 || k != 0) @(negedge clk);
        if (!rst_n) begin
          frames_abrt++;
          return;
        end
        if (k == 0) bits[b] = serial_out;
        else if (serial_out !== bits[b]) glitch++;
        if (tx_if.tx_ready !== 1'b0 || busy !== 1'b1 || tx_done !== 1'b0) flag_err++;
      end
    end
    @(negedge clk);
    if (!rst_n) begin
      frames_abrt++;
      return;
    end
    checkOutput("start_bit", bits[0], 1'b0);
    checkOutput("stop_bit", bits[9], 1'b1);
    checkOutput("bit_width", glitch, 0);
    checkOutput("busy_flags", flag_err, 0);
    if (have_exp) checkOutput("frame_data", bits[8:1], e.data);
    checkOutput("done_pulse", {tx_done, tx_if.tx_ready, serial_out}, 3'b111);
    frames_done++;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && serial_out === 1'b0) runFrame();
    end
  end

  initial begin : stimulus
    int          t;
    int          idle_err;
    int          done_before;
    logic [7:0]  loop_bytes [4];
    loop_bytes = '{8'h00, 8'h7E, 8'hC3, 8'hFF};

    rst_n          = 1'b0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_serial", serial_out, 1'b1);
    checkOutput("rst_ready", tx_if.tx_ready, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", tx_done, 1'b0);
    rst_n = 1'b1;

    idle_err = 0;
    repeat (1000) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || tx_if.tx_ready !== 1'b1 || busy !== 1'b0) idle_err++;
    end
    checkOutput("idle_levels", idle_err, 0);
    checkOutput("idle_no_done", done_cnt, 0);

    t = cyc + 2;
    applyStimulus(8'hA5, t, 1'b0);
    waitUntil(t + FRAME + 5);
    checkOutput("a5_done_count", done_cnt, 1);

    t = cyc + 2;
    applyStimulus(8'h00, t, 1'b1);
    applyStimulus(8'hFF, t + FRAME + 1, 1'b0);
    waitUntil(t + 2 * FRAME + 6);
    checkOutput("b2b_done_count", done_cnt, 3);

    // A one-cycle valid for 0x3C lands in the middle of the 0x81 data bits.
    t = cyc + 2;
    applyStimulus(8'h81, t, 1'b0);
    waitUntil(t + 4 * CPB);
    tx_if.tx_data  = 8'h3C;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    checkOutput("ignore_ready", tx_if.tx_ready, 1'b0);
    tx_if.tx_valid = 1'b0;
    waitUntil(t + FRAME + 200);
    checkOutput("ignore_done_count", done_cnt, 4);

    t = cyc + 2;
    applyStimulus(8'h55, t, 1'b0);
    waitUntil(t + 5 * CPB + 40);
    done_before = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_line", serial_out, 1'b1);
    checkOutput("async_rst_ready", tx_if.tx_ready, 1'b0 == 1'b0 ? 1'b1 : 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    checkOutput("abort_no_done", done_cnt, done_before);
    checkOutput("abort_seen", frames_abrt, 1);

    t = cyc + 2;
    applyStimulus(8'h55, t, 1'b0);
    waitUntil(t + FRAME + 5);
    checkOutput("resend_done_count", done_cnt, 5);

    t = cyc + 2;
    for (int i = 0; i < 4; i++) applyStimulus(loop_bytes[i], t + i * (FRAME + 1), i < 3);
    waitUntil(t + 4 * (FRAME + 1) + 5);

    checkOutput("final_done_count", done_cnt, 9);
    checkOutput("final_frames", frames_done, 9);
    checkOutput("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
